// File: rtl/btb_update_queue.sv
// btb_update_queue: filters taken control-flow commits, buffers them in a FIFO
// and drains one entry per cycle onto the BTB write port.
module btb_update_queue #(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           cm_valid,
    input  logic [1:0]           cm_taken,
    input  logic [1:0][31:0]     cm_pc,
    input  logic [1:0][1:0]      cm_br_type,
    input  logic [1:0][31:0]     cm_npc,
    output logic                 upd_ready,
    output logic                 btb_commit,
    output logic [31:0]          btb_commit_pc,
    output logic [1:0]           btb_commit_pc_type,
    output logic [31:0]          btb_commit_npc,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    localparam logic [PTR_WIDTH:0] READY_MAX = (PTR_WIDTH + 1)'(DEPTH - 2);

    logic [65:0]          r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_WIDTH:0]   r_count;
    logic [65:0]          r_last;
    logic                 r_last_v;
    logic [CNT_WIDTH-1:0] r_drop;

    logic [65:0]          w_e0, w_e1, w_head;
    logic                 w_cand0, w_cand1, w_keep0, w_keep1, w_enq0, w_enq1;
    logic [1:0]           w_n_keep, w_n_enq;
    logic [PTR_WIDTH-1:0] w_slot1_ptr;
    logic [CNT_WIDTH:0]   w_drop_sum;

    assign w_e0    = {cm_npc[0], cm_br_type[0], cm_pc[0]};
    assign w_e1    = {cm_npc[1], cm_br_type[1], cm_pc[1]};
    assign w_cand0 = cm_valid[0] & cm_taken[0];
    assign w_cand1 = cm_valid[1] & cm_taken[1];
    // Duplicates are judged against the entry last written, not the head
    assign w_keep0 = w_cand0 & ~(r_last_v && r_last == w_e0);
    assign w_keep1 = w_cand1 & ~(r_last_v && r_last == w_e1) & ~(w_cand0 && w_e1 == w_e0);
    assign w_n_keep = {1'b0, w_keep0} + {1'b0, w_keep1};

    assign upd_ready   = r_count <= READY_MAX;
    assign w_enq0      = upd_ready & w_keep0;
    assign w_enq1      = upd_ready & w_keep1;
    assign w_n_enq     = upd_ready ? w_n_keep : 2'd0;
    assign w_slot1_ptr = w_enq0 ? r_wr_ptr + PTR_WIDTH'(1) : r_wr_ptr;
    assign w_drop_sum  = {1'b0, r_drop} + (CNT_WIDTH + 1)'(upd_ready ? 2'd0 : w_n_keep);

    assign btb_commit         = r_count != 0;
    assign w_head             = btb_commit ? r_mem[r_rd_ptr] : 66'd0;
    assign btb_commit_pc      = w_head[31:0];
    assign btb_commit_pc_type = w_head[33:32];
    assign btb_commit_npc     = w_head[65:34];
    assign drop_cnt           = r_drop;

    always_ff @(posedge clock) begin
        if (w_enq0) r_mem[r_wr_ptr] <= w_e0;
        if (w_enq1) r_mem[w_slot1_ptr] <= w_e1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
            r_last_v <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(w_n_enq);
            r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(btb_commit);
            r_count  <= r_count + (PTR_WIDTH + 1)'(w_n_enq) - (PTR_WIDTH + 1)'(btb_commit);
            r_drop   <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
            if (w_enq1) r_last <= w_e1;
            else if (w_enq0) r_last <= w_e0;
            if (w_enq0 | w_enq1) r_last_v <= 1'b1;
        end
    end
endmodule
